// File: rtl/serv_wb_rr_arbiter_if.sv
// Wishbone-style bus bundle shared by the SERV ibus, dbus and the memory port.
// master drives the request side, slave returns read data and ack.
interface serv_wb_rr_arbiter_if;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic [31:0] rdt;
  logic        ack;

  modport master (output adr, dat, sel, we, cyc, input  rdt, ack);
  modport slave  (input  adr, dat, sel, we, cyc, output rdt, ack);
endinterface

// File: rtl/serv_wb_rr_arbiter.sv
// Registered round-robin arbiter sharing one memory port between the SERV
// instruction and data buses. A watchdog force-completes a grant whose ack
// never arrives so the CPU cannot hang on a lost external ack.
module serv_wb_rr_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic                         clk,
  input  logic                         i_rst,
  serv_wb_rr_arbiter_if.slave          ibus,
  serv_wb_rr_arbiter_if.slave          dbus,
  serv_wb_rr_arbiter_if.master         mem,
  output logic                         o_timeout
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic          last_d, last_d_nxt;
  logic [TW-1:0] cnt;
  logic          gnt_d;     // current grant belongs to dbus
  logic          req;       // granted master still holds cyc
  logic          ack_x;     // ack (real or forced) to the granted master
  logic [31:0]   rdt_x;
  logic          tmo;

  // State, fairness bit and watchdog counter; counter is held at zero in IDLE
  // so it starts from zero on every grant.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state  <= IDLE;
      last_d <= 1'b1;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      last_d <= last_d_nxt;
      cnt    <= (state == IDLE) ? '0 : cnt + 1'b1;
    end
  end

  // Arbitration, memory-port mux and grant termination (ack, abort, timeout).
  always_comb begin
    state_nxt  = state;
    last_d_nxt = last_d;
    mem.adr    = '0;
    mem.dat    = '0;
    mem.sel    = '0;
    mem.we     = 1'b0;
    mem.cyc    = 1'b0;
    gnt_d      = (state == GNT_D);
    req        = 1'b0;
    ack_x      = 1'b0;
    rdt_x      = '0;
    tmo        = 1'b0;

    case (state)
      IDLE: begin
        // On a tie the master that was not served last wins.
        if (ibus.cyc && dbus.cyc) state_nxt = last_d ? GNT_I : GNT_D;
        else if (ibus.cyc)        state_nxt = GNT_I;
        else if (dbus.cyc)        state_nxt = GNT_D;
      end
      GNT_I: begin
        mem.cyc = 1'b1;
        mem.adr = ibus.adr;
        mem.sel = 4'hF;
        req     = ibus.cyc;
      end
      GNT_D: begin
        mem.cyc = 1'b1;
        mem.adr = dbus.adr;
        mem.dat = dbus.dat;
        mem.sel = dbus.sel;
        mem.we  = dbus.we;
        req     = dbus.cyc;
      end
      default: state_nxt = IDLE;
    endcase

    // A real ack beats both abort and timeout on the same cycle.
    if (state != IDLE) begin
      if (mem.ack) begin
        ack_x = 1'b1;
        rdt_x = mem.rdt;
      end else if (req && (cnt == TMO_LAST)) begin
        ack_x = 1'b1;
        tmo   = 1'b1;
      end
      if (mem.ack || !req || (cnt == TMO_LAST)) begin
        state_nxt  = IDLE;
        last_d_nxt = gnt_d;
      end
    end

    // Nothing is acknowledged while reset is being applied.
    if (i_rst) begin
      ack_x = 1'b0;
      rdt_x = '0;
      tmo   = 1'b0;
    end
  end

  // Return path: only the granted master ever sees ack or read data.
  always_comb begin
    ibus.ack  = ack_x && !gnt_d;
    ibus.rdt  = (ack_x && !gnt_d) ? rdt_x : '0;
    dbus.ack  = ack_x && gnt_d;
    dbus.rdt  = (ack_x && gnt_d) ? rdt_x : '0;
    o_timeout = tmo;
  end

endmodule

// File: tb/tb_serv_wb_rr_arbiter.sv
// Bench for serv_wb_rr_arbiter: directed scenarios followed by random traffic.
// Each driven cycle pushes the expected outputs into a queue; a negedge
// monitor pops and compares them against the DUT.
module tb_serv_wb_rr_arbiter;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tmo_o;
  always #5 clk = ~clk;

  serv_wb_rr_arbiter_if ib ();
  serv_wb_rr_arbiter_if db ();
  serv_wb_rr_arbiter_if mb ();

  serv_wb_rr_arbiter #(.TIMEOUT(TMO), .TW(8)) dut (
    .clk       (clk),
    .i_rst     (rst),
    .ibus      (ib),
    .dbus      (db),
    .mem       (mb),
    .o_timeout (tmo_o)
  );

  typedef struct packed {
    logic        cyc;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        iack;
    logic [31:0] irdt;
    logic        dack;
    logic [31:0] drdt;
    logic        tmo;
  } exp_t;

  exp_t  expq[$];
  exp_t  last_e;
  int    checks = 0;
  int    errors = 0;

  // Reference model: who owns the port (0 none, 1 ibus, 2 dbus), who was
  // served last, and how many grant cycles have passed without an ack.
  int    m_owner  = 0;
  bit    m_last_d = 1'b1;
  int    m_wait   = 0;

  bit    logging = 1'b0;
  string order_s = "";
  int    tmo_cnt = 0;
  logic  prev_cyc = 1'b0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // Predict this cycle's outputs from the current inputs, advance the model,
  // then move to the next cycle.
  task automatic step();
    exp_t e;
    bit   req, done, ack;
    e = '0;
    if (m_owner == 1) begin
      e.cyc = 1'b1; e.adr = ib.adr; e.sel = 4'hF;
    end else if (m_owner == 2) begin
      e.cyc = 1'b1; e.adr = db.adr; e.dat = db.dat; e.sel = db.sel; e.we = db.we;
    end
    if (rst) begin
      m_owner = 0; m_last_d = 1'b1; m_wait = 0;
    end else if (m_owner == 0) begin
      if (ib.cyc && db.cyc) m_owner = m_last_d ? 1 : 2;
      else if (ib.cyc)      m_owner = 1;
      else if (db.cyc)      m_owner = 2;
      m_wait = 0;
    end else begin
      req  = (m_owner == 1) ? ib.cyc : db.cyc;
      done = 1'b1;
      ack  = 1'b0;
      if (mb.ack) begin
        ack = 1'b1;
        if (m_owner == 1) e.irdt = mb.rdt; else e.drdt = mb.rdt;
      end else if (!req) begin
        ack = 1'b0;
      end else if (m_wait == TMO - 1) begin
        ack = 1'b1; e.tmo = 1'b1;
      end else begin
        done = 1'b0; m_wait++;
      end
      if (ack) begin
        if (m_owner == 1) e.iack = 1'b1; else e.dack = 1'b1;
      end
      if (done) begin
        m_last_d = (m_owner == 2);
        m_owner  = 0;
      end
    end
    expq.push_back(e);
    last_e = e;
    @(posedge clk); #1;
  endtask

  // Monitor: compare every driven cycle; also log grant order and timeouts.
  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("mem_cyc", mb.cyc, e.cyc);
      chk("mem_adr", mb.adr, e.adr);
      chk("mem_dat", mb.dat, e.dat);
      chk("mem_sel", mb.sel, e.sel);
      chk("mem_we",  mb.we,  e.we);
      chk("ibus_ack", ib.ack, e.iack);
      chk("ibus_rdt", ib.rdt, e.irdt);
      chk("dbus_ack", db.ack, e.dack);
      chk("dbus_rdt", db.rdt, e.drdt);
      chk("timeout", tmo_o, e.tmo);
      if (logging && mb.cyc && !prev_cyc) order_s = {order_s, mb.adr[29] ? "D" : "I"};
      if (tmo_o) tmo_cnt++;
      prev_cyc = mb.cyc;
    end
  end

  task automatic chk_str(input string n, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got '%s' expected '%s'", n, act, exp);
    end
  endtask

  initial begin
    ib.adr = '0; ib.dat = '0; ib.sel = '0; ib.we = 1'b0; ib.cyc = 1'b0;
    db.adr = '0; db.dat = '0; db.sel = '0; db.we = 1'b0; db.cyc = 1'b0;
    mb.ack = 1'b0; mb.rdt = '0;
    @(posedge clk); #1;

    // Reset state
    step(); step();
    rst = 1'b0;
    step();

    // ibus alone, ack on the second grant cycle
    ib.cyc = 1'b1; ib.adr = 32'h10;
    step(); step();
    mb.ack = 1'b1; mb.rdt = 32'h0000_0013;
    step();
    mb.ack = 1'b0; ib.cyc = 1'b0;
    step(); step();

    // Simultaneous request after reset: ibus first, dbus after one bubble
    rst = 1'b1; step(); rst = 1'b0;
    order_s = ""; logging = 1'b1;
    ib.cyc = 1'b1; ib.adr = 32'h1000_0004;
    db.cyc = 1'b1; db.adr = 32'h2000_0008; db.dat = 32'hDEAD_BEEF; db.sel = 4'h3; db.we = 1'b1;
    step(); step();
    mb.ack = 1'b1; mb.rdt = 32'hCAFE_0001; step();
    mb.ack = 1'b0; ib.cyc = 1'b0; step(); step();
    mb.ack = 1'b1; mb.rdt = 32'hCAFE_0002; step();
    mb.ack = 1'b0; db.cyc = 1'b0; step(); step();
    logging = 1'b0;
    chk_str("tie_after_reset_order", order_s, "ID");

    // Continuous contention alternates grants
    order_s = ""; logging = 1'b1;
    ib.cyc = 1'b1; ib.adr = 32'h1000_0100;
    db.cyc = 1'b1; db.adr = 32'h2000_0200; db.we = 1'b0; db.sel = 4'hF;
    begin
      int n = 0;
      for (int k = 0; k < 40 && n < 4; k++) begin
        mb.ack = (m_owner != 0);
        mb.rdt = $urandom;
        if (m_owner != 0) n++;
        step();
      end
    end
    mb.ack = 1'b0; ib.cyc = 1'b0; db.cyc = 1'b0;
    step(); step();
    logging = 1'b0;
    chk_str("alternation_order", order_s, "IDID");

    // dbus without ack: watchdog fires on the 4th grant cycle
    tmo_cnt = 0;
    db.cyc = 1'b1; db.adr = 32'h2000_0010;
    for (int k = 0; k < 5; k++) step();
    db.cyc = 1'b0;
    step(); step();
    chk("timeout_pulses", tmo_cnt, 1);

    // Stray ack while idle
    mb.ack = 1'b1; mb.rdt = 32'hFFFF_FFFF;
    step(); step();
    mb.ack = 1'b0;

    // Reset during a dbus grant, then a tie goes to ibus
    db.cyc = 1'b1; db.adr = 32'h2000_0020;
    step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    order_s = ""; logging = 1'b1;
    ib.cyc = 1'b1; ib.adr = 32'h1000_0030;
    step(); step();
    mb.ack = 1'b1; mb.rdt = 32'h1234_5678; step();
    mb.ack = 1'b0; ib.cyc = 1'b0; db.cyc = 1'b0;
    step(); step();
    logging = 1'b0;
    chk_str("tie_after_mid_reset", order_s, "I");

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      rst    = ($urandom_range(0, 199) == 0);
      mb.rdt = $urandom;
      mb.ack = (m_owner != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      if (!ib.cyc) begin
        if ($urandom_range(0, 1) == 1) begin ib.cyc = 1'b1; ib.adr = {4'h1, 28'($urandom)}; end
      end else if (last_e.iack) begin
        if ($urandom_range(0, 1) == 1) ib.cyc = 1'b0; else ib.adr = {4'h1, 28'($urandom)};
      end else if ($urandom_range(0, 29) == 0) ib.cyc = 1'b0;
      if (!db.cyc) begin
        if ($urandom_range(0, 1) == 1) begin
          db.cyc = 1'b1; db.adr = {4'h2, 28'($urandom)}; db.dat = $urandom;
          db.sel = 4'($urandom); db.we = 1'($urandom);
        end
      end else if (last_e.dack) begin
        if ($urandom_range(0, 1) == 1) db.cyc = 1'b0;
        else begin db.adr = {4'h2, 28'($urandom)}; db.dat = $urandom; db.we = 1'($urandom); end
      end else if ($urandom_range(0, 29) == 0) db.cyc = 1'b0;
      step();
    end

    rst = 1'b0; mb.ack = 1'b0; ib.cyc = 1'b0; db.cyc = 1'b0;
    step(); step(); step();
    @(negedge clk); @(negedge clk);
    chk("queue_drained", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
